// File: rtl/hall_lighting_pkg.sv
// rtl/hall_lighting_pkg.sv - shared types and defaults for the hall sensor front end
//
// Purpose: channel state encoding, default timing constants and channel indices
//          used by hall_sensor_conditioner and sensor_debounce_channel.
// Ports:   none (package).
package hall_lighting_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } chan_state_t;

    // 10 ms at 100 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_CNT_W           = 20;
    // 10 s at 100 MHz; the integrator scales this to fit CNT_W
    localparam int DEF_STUCK_CYCLES    = 1_000_000_000;

    localparam int CH_ENTRY = 0;
    localparam int CH_EXIT  = 1;

endpackage

// File: rtl/sensor_debounce_channel.sv
// rtl/sensor_debounce_channel.sv - synchroniser, debounce FSM and stuck detector for one sensor
//
// Purpose: brings one raw asynchronous sensor pin into the clk domain, accepts a
//          level change only after DEBOUNCE_CYCLES consecutive identical samples,
//          and emits a one-cycle pulse on each accepted rising transition.
//          Optional stuck-high detection is built only when
//          HALL_SENSOR_STUCK_DETECT_EN is defined.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   i_raw    in   raw sensor pin, asynchronous to clk
//   o_pulse  out  one-cycle strobe on accepted rising transition
//   o_level  out  debounced level
//   o_fault  out  sensor held active for STUCK_CYCLES (0 when feature not built)
module sensor_debounce_channel
    import hall_lighting_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int STUCK_CYCLES    = DEF_STUCK_CYCLES
)(
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_pulse,
    output logic o_level,
    output logic o_fault
);

    // The sample that leaves IDLE/HIGH already counts as the first stable one,
    // so the D-th consecutive sample is accepted while cnt still holds D-1.
    // This gives an acceptance edge of D+1 after raw is first sampled.
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit               LP_SINGLE   = (DEBOUNCE_CYCLES == 1);

    logic             r_s1;
    logic             r_s2;
    chan_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;
    logic             r_level;

    logic w_rise_accept;
    logic w_fall_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
        end
    end

    assign w_rise_accept = r_s2 &&
                           (((r_state == IDLE) && LP_SINGLE) ||
                            ((r_state == RISE_CHK) && (r_cnt == LP_CNT_LAST)));
    assign w_fall_accept = !r_s2 &&
                           (((r_state == HIGH) && LP_SINGLE) ||
                            ((r_state == FALL_CHK) && (r_cnt == LP_CNT_LAST)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rise_accept) begin
                        r_state <= HIGH;
                        r_level <= 1'b1;
                        r_pulse <= 1'b1;
                        r_cnt   <= '0;
                    end else if (r_s2) begin
                        r_state <= RISE_CHK;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                RISE_CHK: begin
                    if (!r_s2) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (w_rise_accept) begin
                        r_state <= HIGH;
                        r_level <= 1'b1;
                        r_pulse <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (w_fall_accept) begin
                        r_state <= IDLE;
                        r_level <= 1'b0;
                        r_cnt   <= '0;
                    end else if (!r_s2) begin
                        r_state <= FALL_CHK;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                FALL_CHK: begin
                    if (r_s2) begin
                        r_state <= HIGH;
                        r_cnt   <= '0;
                    end else if (w_fall_accept) begin
                        r_state <= IDLE;
                        r_level <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_level <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_pulse = r_pulse;
    assign o_level = r_level;

`ifdef HALL_SENSOR_STUCK_DETECT_EN
    localparam logic [CNT_W-1:0] LP_STUCK_LAST = CNT_W'(STUCK_CYCLES - 1);

    logic [CNT_W-1:0] r_stuck_cnt;
    logic             r_fault;

    // Counts only while sitting in HIGH; a brief dip into FALL_CHK pauses it
    // rather than restarting it. Cleared on the same edge the level drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stuck_cnt <= '0;
            r_fault     <= 1'b0;
        end else if (w_fall_accept) begin
            r_stuck_cnt <= '0;
            r_fault     <= 1'b0;
        end else if ((r_state == HIGH) && !r_fault) begin
            if (r_stuck_cnt == LP_STUCK_LAST) begin
                r_fault <= 1'b1;
            end else begin
                r_stuck_cnt <= r_stuck_cnt + CNT_W'(1);
            end
        end
    end

    assign o_fault = r_fault;
`else
    logic w_unused_stuck;
    assign w_unused_stuck = (STUCK_CYCLES > 0);
    assign o_fault        = 1'b0;
`endif

endmodule

// File: rtl/hall_sensor_conditioner.sv
// rtl/hall_sensor_conditioner.sv - entry/exit sensor synchronise and debounce front end
//
// Purpose: two independent debounce channels (entry, exit) feeding the occupancy
//          counter with clean rising-edge pulses and debounced levels.
//          Optional macro: HALL_SENSOR_STUCK_DETECT_EN builds stuck-high detection;
//          without it sensor_fault is constant 2'b00.
// Ports:
//   clk               in   system clock
//   rst_n             in   asynchronous active-low reset
//   entry_sensor_raw  in   raw entry pin, asynchronous to clk
//   exit_sensor_raw   in   raw exit pin, asynchronous to clk
//   entry_pulse       out  one-cycle strobe on accepted entry rise
//   exit_pulse        out  one-cycle strobe on accepted exit rise
//   entry_level       out  debounced entry level
//   exit_level        out  debounced exit level
//   sensor_fault[1:0] out  [0]=entry stuck, [1]=exit stuck
module hall_sensor_conditioner
    import hall_lighting_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int STUCK_CYCLES    = DEF_STUCK_CYCLES
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       entry_sensor_raw,
    input  logic       exit_sensor_raw,
    output logic       entry_pulse,
    output logic       exit_pulse,
    output logic       entry_level,
    output logic       exit_level,
    output logic [1:0] sensor_fault
);

    logic w_entry_fault;
    logic w_exit_fault;

    sensor_debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_entry (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (entry_sensor_raw),
        .o_pulse (entry_pulse),
        .o_level (entry_level),
        .o_fault (w_entry_fault)
    );

    sensor_debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_exit (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (exit_sensor_raw),
        .o_pulse (exit_pulse),
        .o_level (exit_level),
        .o_fault (w_exit_fault)
    );

    assign sensor_fault[CH_ENTRY] = w_entry_fault;
    assign sensor_fault[CH_EXIT]  = w_exit_fault;

endmodule
